sm_addsub_pipe: RTL and testbench
=================================

SM_ADDSUB_PIPE -- requirements
Module: sm_addsub_pipe

Interface
REQ-001 Parameter W, default 24: magnitude width of operands and result, legal range 4..64.
REQ-002 Parameter LZW, default $clog2(W+1): width of the leading-zero-count output.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand set on the input bus is valid.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 op  input  1  0 = A+B, 1 = A-B.
REQ-008 a_sign, b_sign  input  1 each  operand signs, 1 = negative.
REQ-009 a_mag, b_mag  input  W each  unsigned operand magnitudes.
REQ-010 out_valid  output  1  result bus valid.
REQ-011 out_ready  input  1  downstream consumes the result this cycle.
REQ-012 sum_mag  output  W  result magnitude.
REQ-013 sum_sign  output  1  result sign.
REQ-014 carry  output  1  magnitude overflow (bit W of the addition).
REQ-015 zero  output  1  result is exactly zero.
REQ-016 lzc  output  LZW  leading zeros of sum_mag, for the downstream normaliser.

Function
REQ-017 Input transfer occurs on a cycle with in_valid=1 and in_ready=1; output transfer on a cycle with out_valid=1 and out_ready=1.
REQ-018 Two register stages: S1 = effective-op decode, magnitude compare, operand swap; S2 = add/subtract, zero detect, lzc.
REQ-019 Latency is exactly 2 cycles from input transfer to out_valid with no stall; throughput is one result per cycle when out_ready stays 1.
REQ-020 eff_sub = a_sign XOR b_sign XOR op; effective B sign = b_sign XOR op.
REQ-021 eff_sub=0: {carry,sum_mag} = a_mag + b_mag (W+1 bits), sum_sign = a_sign.
REQ-022 eff_sub=1, a_mag >= b_mag: sum_mag = a_mag - b_mag, sum_sign = a_sign, carry = 0.
REQ-023 eff_sub=1, a_mag < b_mag: sum_mag = b_mag - a_mag, sum_sign = b_sign XOR op, carry = 0.
REQ-024 zero = 1 iff sum_mag = 0 and carry = 0; when zero = 1, sum_sign is forced to 0 (no negative zero, including -0 + -0).
REQ-025 lzc = 0 when carry = 1; lzc = W when zero = 1; otherwise the count of leading zero bits of sum_mag.
REQ-026 Stage-advance rule: S2 loads when S2 is empty or its result transfers this cycle; S1 loads when S1 is empty or S1 advances into S2.
REQ-027 in_ready = (S1 empty) OR (S1 advances this cycle); in_ready is independent of in_valid.
REQ-028 While out_valid=1 and out_ready=0, every output holds stable and no accepted operand is dropped or reordered.
REQ-029 With out_ready held 0, the block accepts at most 2 operand sets, then in_ready = 0 until out_ready returns to 1.
REQ-030 Simultaneous output transfer and input transfer in one cycle with both stages full: all three transactions proceed; no bubble is inserted.
REQ-031 Inputs without in_valid=1 and in_ready=1 are ignored; op, signs and magnitudes are sampled only on input transfer.

Reset
REQ-032 While rst=1, S1 and S2 valid flags clear; out_valid = 0, in_ready = 0, sum_mag = 0, sum_sign = 0, carry = 0, zero = 0, lzc = 0.
REQ-033 On the first cycle after rst deasserts, in_ready = 1.
REQ-034 Reset asserted mid-operation discards all in-flight operands; no result from before reset ever appears on the output.

Verification (W=24)
REQ-035 +5 add +3 (op=0), out_ready=1 -> 2 cycles later: sum_mag=8, sum_sign=0, carry=0, zero=0, lzc=20.
REQ-036 +3 minus +5 (op=1) -> sum_mag=2, sum_sign=1, carry=0, lzc=22; also -3 add +5 -> sum_mag=2, sum_sign=0.
REQ-037 +0xFFFFFF add +1 -> sum_mag=0, carry=1, zero=0, lzc=0; -7 minus -7 -> sum_mag=0, sum_sign=0, zero=1, lzc=24.
REQ-038 Backpressure: 4 back-to-back inputs (1,2,3,4 each +1) with out_ready=0 for 5 cycles -> in_ready=0 after 2 accepted; outputs hold 2; after out_ready=1 the results 2,3,4,5 arrive in order with none lost.
REQ-039 Streaming: 16 consecutive random operand sets with out_ready=1 -> 16 results on consecutive cycles, each matching a sign-magnitude reference model.
REQ-040 Assert rst one cycle after 2 inputs are accepted -> out_valid stays 0 through reset and after it; the next input produces only its own result, 2 cycles after transfer.

Source files
------------

// File: rtl/sm_addsub_pipe.sv
// sm_addsub_pipe: two-stage pipelined sign-magnitude adder/subtractor.
//   Stage 1 decodes the effective operation, compares magnitudes and
//   orders the operands so stage 2 only ever computes big+small or big-small.
//   Stage 2 performs the add/subtract and derives zero and leading-zero count.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready does not depend on in_valid)
//   op                    0 = A+B, 1 = A-B
//   a_sign, a_mag         operand A (sign 1 = negative, unsigned magnitude)
//   b_sign, b_mag         operand B
//   out_valid / out_ready result handshake
//   sum_mag, sum_sign     result magnitude and sign (never negative zero)
//   carry                 magnitude overflow, bit W of the addition
//   zero                  result is exactly zero
//   lzc                   leading zeros of sum_mag (0 on carry, W on zero)
module sm_addsub_pipe #(
  parameter int unsigned W   = 24,
  parameter int unsigned LZW = $clog2(W + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           op,
  input  logic           a_sign,
  input  logic           b_sign,
  input  logic [W-1:0]   a_mag,
  input  logic [W-1:0]   b_mag,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   sum_mag,
  output logic           sum_sign,
  output logic           carry,
  output logic           zero,
  output logic [LZW-1:0] lzc
);

  // Stage 1 registers: ordered operands and the sign the result will carry.
  logic           r_s1_valid;
  logic           r_s1_eff_sub;
  logic           r_s1_sign;
  logic [W-1:0]   r_s1_big;
  logic [W-1:0]   r_s1_small;

  // Stage 2 registers drive the result bus directly.
  logic           r_s2_valid;
  logic [W-1:0]   r_sum_mag;
  logic           r_sum_sign;
  logic           r_carry;
  logic           r_zero;
  logic [LZW-1:0] r_lzc;

  // Handshake / stage-advance wires.
  logic           w_out_xfer;
  logic           w_s2_load;
  logic           w_s1_load;
  logic           w_in_xfer;

  // Stage 1 combinational decode.
  logic           w_eff_sub;
  logic           w_a_ge_b;
  logic [W-1:0]   w_big;
  logic [W-1:0]   w_small;
  logic           w_s1_sign;

  // Stage 2 combinational arithmetic.
  logic [W:0]     w_sum_ext;
  logic [W-1:0]   w_mag;
  logic           w_carry;
  logic           w_zero;
  logic           w_sign;
  logic [LZW-1:0] w_lzc;
  logic           w_found;

  // Result bus; out_valid is masked during reset so a result captured just
  // before reset can never be presented or consumed while rst is high.
  assign out_valid = r_s2_valid & ~rst;
  assign sum_mag   = r_sum_mag;
  assign sum_sign  = r_sum_sign;
  assign carry     = r_carry;
  assign zero      = r_zero;
  assign lzc       = r_lzc;

  // Stage advance: S2 refills when empty or draining; a full S1 advances
  // exactly when S2 refills, so S1 can load whenever it is empty or S2 loads.
  assign w_out_xfer = out_valid & out_ready;
  assign w_s2_load  = ~r_s2_valid | w_out_xfer;
  assign w_s1_load  = ~r_s1_valid | w_s2_load;
  assign in_ready   = ~rst & w_s1_load;
  assign w_in_xfer  = in_valid & in_ready;

  // Stage 1 decode: effective op and operand ordering by magnitude.
  always_comb begin
    w_eff_sub = a_sign ^ b_sign ^ op;
    w_a_ge_b  = (a_mag >= b_mag);
    w_big     = a_mag;
    w_small   = b_mag;
    w_s1_sign = a_sign;
    if (w_eff_sub && !w_a_ge_b) begin
      w_big     = b_mag;
      w_small   = a_mag;
      w_s1_sign = b_sign ^ op;
    end
  end

  // Stage 1 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_eff_sub <= 1'b0;
      r_s1_sign    <= 1'b0;
      r_s1_big     <= '0;
      r_s1_small   <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= w_in_xfer;
      if (w_in_xfer) begin
        r_s1_eff_sub <= w_eff_sub;
        r_s1_sign    <= w_s1_sign;
        r_s1_big     <= w_big;
        r_s1_small   <= w_small;
      end
    end
  end

  // Stage 2 arithmetic: ordered operands mean subtraction never borrows.
  always_comb begin
    if (r_s1_eff_sub) begin
      w_sum_ext = {1'b0, r_s1_big - r_s1_small};
    end else begin
      w_sum_ext = {1'b0, r_s1_big} + {1'b0, r_s1_small};
    end
    w_carry = w_sum_ext[W];
    w_mag   = w_sum_ext[W-1:0];
    w_zero  = ~w_carry & (w_mag == '0);
    w_sign  = r_s1_sign & ~w_zero;
  end

  // Leading-zero count; an all-zero magnitude falls through to W.
  always_comb begin
    w_lzc   = LZW'(W);
    w_found = 1'b0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (!w_found && w_mag[i]) begin
        w_lzc   = LZW'(int'(W) - 1 - i);
        w_found = 1'b1;
      end
    end
    if (w_carry) begin
      w_lzc = '0;
    end
  end

  // Stage 2 register; result fields hold while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_sum_mag  <= '0;
      r_sum_sign <= 1'b0;
      r_carry    <= 1'b0;
      r_zero     <= 1'b0;
      r_lzc      <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sum_mag  <= w_mag;
        r_sum_sign <= w_sign;
        r_carry    <= w_carry;
        r_zero     <= w_zero;
        r_lzc      <= w_lzc;
      end
    end
  end

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Bench for sm_addsub_pipe: signed-integer reference model feeding a
// scoreboard queue, one negedge monitor checking every output transfer.
module tb_sm_addsub_pipe;
  localparam int unsigned W   = 24;
  localparam int unsigned LZW = $clog2(W + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic           op;
  logic           a_sign;
  logic           b_sign;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   sum_mag;
  logic           sum_sign;
  logic           carry;
  logic           zero;
  logic [LZW-1:0] lzc;

  typedef struct {
    logic [W-1:0]   mag;
    logic           sign;
    logic           carry;
    logic           zero;
    logic [LZW-1:0] lzc;
    int             cyc;
  } exp_t;

  exp_t q[$];
  exp_t held;
  int   checks     = 0;
  int   failures   = 0;
  int   cyc        = 0;
  int   n_acc      = 0;
  int   n_out      = 0;
  bit   lat_strict = 1'b0;
  bit   hold_chk   = 1'b0;

  sm_addsub_pipe #(.W(W), .LZW(LZW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a_sign    (a_sign),
    .b_sign    (b_sign),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_mag   (sum_mag),
    .sum_sign  (sum_sign),
    .carry     (carry),
    .zero      (zero),
    .lzc       (lzc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: treat operands as signed integers and add.
  function automatic exp_t model(input logic o, input logic as, input logic bs,
                                 input logic [W-1:0] am, input logic [W-1:0] bm);
    exp_t    e;
    longint  va, vb, r, m;
    int      bl;
    logic [W-1:0] t;
    va      = as ? -longint'(am) : longint'(am);
    vb      = (bs ^ o) ? -longint'(bm) : longint'(bm);
    r       = va + vb;
    m       = (r < 0) ? -r : r;
    e.carry = (m >= (longint'(1) << W));
    e.mag   = m[W-1:0];
    e.zero  = (m == 0);
    e.sign  = (r < 0);
    bl = 0;
    t  = e.mag;
    while (t != '0) begin
      t = t >> 1;
      bl++;
    end
    e.lzc = e.carry ? '0 : LZW'(int'(W) - bl);
    e.cyc = 0;
    return e;
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      q.delete();
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_mag",   64'(sum_mag),  64'(held.mag));
        chk("hold_sign",  64'(sum_sign), 64'(held.sign));
        chk("hold_carry", 64'(carry),    64'(held.carry));
        chk("hold_zero",  64'(zero),     64'(held.zero));
        chk("hold_lzc",   64'(lzc),      64'(held.lzc));
      end
      if (out_valid && q.size() == 0) begin
        chk("spurious_out_valid", 64'(1), 64'(0));
      end else if (out_valid && out_ready) begin
        e = q.pop_front();
        chk("sum_mag",  64'(sum_mag),  64'(e.mag));
        chk("sum_sign", 64'(sum_sign), 64'(e.sign));
        chk("carry",    64'(carry),    64'(e.carry));
        chk("zero",     64'(zero),     64'(e.zero));
        chk("lzc",      64'(lzc),      64'(e.lzc));
        if (lat_strict) chk("latency", 64'(cyc - e.cyc), 64'(2));
        n_out++;
      end
      hold_chk   = out_valid && !out_ready;
      held.mag   = sum_mag;
      held.sign  = sum_sign;
      held.carry = carry;
      held.zero  = zero;
      held.lzc   = lzc;
      if (in_valid && in_ready) begin
        e     = model(op, a_sign, b_sign, a_mag, b_mag);
        e.cyc = cyc;
        q.push_back(e);
        n_acc++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set and hold it until accepted (bounded).
  task automatic send(input logic o, input logic as, input logic bs,
                      input logic [W-1:0] am, input logic [W-1:0] bm);
    int n;
    bit ok;
    op = o; a_sign = as; b_sign = bs; a_mag = am; b_mag = bm;
    in_valid = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      n++;
    end
    if (!ok) chk("send_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = 1'($urandom);
    a_sign   = 1'($urandom);
    b_sign   = 1'($urandom);
    a_mag    = W'($urandom);
    b_mag    = W'($urandom);
  endtask

  task automatic rand_ops(output logic o, output logic as, output logic bs,
                          output logic [W-1:0] am, output logic [W-1:0] bm);
    int k;
    k  = int'($urandom_range(0, 5));
    o  = 1'($urandom);
    as = 1'($urandom);
    bs = 1'($urandom);
    am = W'($urandom);
    bm = W'($urandom);
    case (k)
      1: bm = am;
      2: am = '0;
      3: begin am = '1; bm = '1; end
      4: begin am = W'($urandom_range(0, 15)); bm = W'($urandom_range(0, 15)); end
      default: ;
    endcase
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      tick();
      n++;
    end
    chk(name, 64'(q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic o, as, bs;
    logic [W-1:0] am, bm;
    int base;
    bit done;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = 1'b0; a_sign = 1'b0; b_sign = 1'b0; a_mag = '0; b_mag = '0;

    // Pin the reference model with hand-computed values.
    e = model(1'b0, 1'b0, 1'b0, 24'd5, 24'd3);
    chk("pin_add_mag", 64'(e.mag), 64'(8));
    chk("pin_add_lzc", 64'(e.lzc), 64'(20));
    e = model(1'b1, 1'b0, 1'b0, 24'd3, 24'd5);
    chk("pin_sub_mag", 64'(e.mag), 64'(2));
    chk("pin_sub_sign", 64'(e.sign), 64'(1));
    chk("pin_sub_lzc", 64'(e.lzc), 64'(22));
    e = model(1'b0, 1'b1, 1'b0, 24'd3, 24'd5);
    chk("pin_neg_add_sign", 64'(e.sign), 64'(0));
    e = model(1'b0, 1'b0, 1'b0, 24'hFFFFFF, 24'd1);
    chk("pin_ovf_mag", 64'(e.mag), 64'(0));
    chk("pin_ovf_carry", 64'(e.carry), 64'(1));
    chk("pin_ovf_lzc", 64'(e.lzc), 64'(0));
    e = model(1'b1, 1'b1, 1'b1, 24'd7, 24'd7);
    chk("pin_zero_zero", 64'(e.zero), 64'(1));
    chk("pin_zero_sign", 64'(e.sign), 64'(0));
    chk("pin_zero_lzc", 64'(e.lzc), 64'(24));

    // Reset state.
    repeat (3) tick();
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_sum_mag", 64'(sum_mag), 64'(0));
    chk("rst_sum_sign", 64'(sum_sign), 64'(0));
    chk("rst_carry", 64'(carry), 64'(0));
    chk("rst_zero", 64'(zero), 64'(0));
    chk("rst_lzc", 64'(lzc), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    tick();

    // Directed arithmetic cases, back to back, strict latency.
    lat_strict = 1'b1;
    send(1'b0, 1'b0, 1'b0, 24'd5, 24'd3);
    send(1'b1, 1'b0, 1'b0, 24'd3, 24'd5);
    send(1'b0, 1'b1, 1'b0, 24'd3, 24'd5);
    send(1'b0, 1'b0, 1'b0, 24'hFFFFFF, 24'd1);
    send(1'b1, 1'b1, 1'b1, 24'd7, 24'd7);
    send(1'b0, 1'b1, 1'b1, 24'd0, 24'd0);
    drain("drain_directed");

    // Backpressure: two accepted, then in_ready low until out_ready returns.
    lat_strict = 1'b0;
    tick();
    base = n_acc;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 4; i++) send(1'b0, 1'b0, 1'b0, W'(i), 24'd1);
      end
      begin
        repeat (5) tick();
        chk("bp_accepted", 64'(n_acc - base), 64'(2));
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        chk("bp_out_valid", 64'(out_valid), 64'(1));
        chk("bp_head_mag", 64'(sum_mag), 64'(2));
        out_ready = 1'b1;
      end
    join
    drain("drain_bp");
    chk("bp_total", 64'(n_acc - base), 64'(4));

    // Streaming: 16 random sets, one result per cycle.
    lat_strict = 1'b1;
    base = n_out;
    for (int i = 0; i < 16; i++) begin
      rand_ops(o, as, bs, am, bm);
      send(o, as, bs, am, bm);
    end
    drain("drain_stream");
    chk("stream_count", 64'(n_out - base), 64'(16));

    // Reset mid-flight discards both in-flight operands.
    send(1'b0, 1'b0, 1'b0, 24'd100, 24'd1);
    send(1'b0, 1'b0, 1'b0, 24'd200, 24'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    tick();
    tick();
    chk("midrst_out_valid2", 64'(out_valid), 64'(0));
    chk("midrst_sum_mag", 64'(sum_mag), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(0));
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postrst_out_valid", 64'(out_valid), 64'(0));
    end
    tick();
    base = n_out;
    send(1'b1, 1'b0, 1'b1, 24'd9, 24'd4);
    drain("drain_postrst");
    chk("postrst_one_result", 64'(n_out - base), 64'(1));

    // Random traffic with random backpressure and input gaps.
    lat_strict = 1'b0;
    base = n_out;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          rand_ops(o, as, bs, am, bm);
          repeat (int'($urandom_range(0, 2))) tick();
          send(o, as, bs, am, bm);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          tick();
          out_ready = 1'($urandom);
        end
        out_ready = 1'b1;
      end
    join
    drain("drain_random");
    chk("random_count", 64'(n_out - base), 64'(300));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
